key_sweep_ctrl: RTL and testbench
=================================

// Module: key_sweep_ctrl
// PURPOSE
//  Sequential driver and consumer for the locked-vs-original miter (orgcir/enccir pair).
//  Sweeps locking-key candidates 0..2^KEY_W-1 ascending. For each candidate it applies
//  every primary-input pattern 0..2^IN_W-1 and samples the miter's Z (all-outputs-equal).
//  Reports the first key that matches on all patterns. Sits directly upstream of the
//  miter (drives lockingkeyinput and the N* inputs) and downstream of it (consumes Z/Q).
// PARAMETERS
//  KEY_W   5   width of lockingkeyinput candidate
//  IN_W    5   number of primary inputs driven (packed, pi[0]=first input)
//  OUT_W   2   width of miter per-output equality vector Q
// PORTS
//  C            in   1       clock, rising edge
//  R            in   1       reset, asynchronous, active-low
//  start        in   1       1-cycle pulse; begins sweep when idle
//  key          out  KEY_W   registered key candidate -> miter lockingkeyinput
//  pi           out  IN_W    registered input pattern -> miter primary inputs
//  z            in   1       miter Z (combinational from key/pi)
//  q            in   OUT_W   miter Q per-output equality
//  busy         out  1       sweep in progress
//  done         out  1       1-cycle pulse at sweep end
//  found        out  1       sticky: a fully matching key was found
//  key_found    out  KEY_W   matching key, valid while found=1
//  bad_out      out  OUT_W   sticky OR of ~q over all samples of current sweep
//  rejected_cnt out  KEY_W+1 keys rejected in current sweep (see CONFIGURATION)
// BEHAVIOUR
//  Reset (R=0, async): state=IDLE; key=0, pi=0, busy=0, done=0, found=0,
//   key_found=0, bad_out=0, rejected_cnt=0.
//  States: IDLE, SWEEP, FINISH.
//  IDLE: start=1 -> SWEEP. Clear key, pi, found, key_found, bad_out, rejected_cnt.
//   busy=1 from next cycle. start is ignored outside IDLE.
//  SWEEP: one pattern per cycle. z/q sampled at the rising edge while key/pi are stable.
//   - bad_out |= ~q every SWEEP cycle.
//   - z=0: reject key. rejected_cnt++. pi<=0.
//       If key==all-ones -> FINISH with found=0; else key++.
//   - z=1 and pi==all-ones: found<=1, key_found<=key -> FINISH.
//   - z=1 otherwise: pi++ (key held).
//  FINISH: done=1 for exactly one cycle, busy<=0 -> IDLE. key/pi hold last values.
//  Latency: start edge to first sample = 1 cycle. Worst case with no match:
//   2^KEY_W * 2^IN_W + 2 cycles.
//  Wrap-around: key and pi never wrap. All-ones is terminal for key; for pi it ends the
//   candidate.
//  Simultaneous events: start coincident with FINISH is ignored. start is sampled only
//   in IDLE.
//  Reset mid-sweep: immediate return to IDLE, all outputs at reset values, no done pulse.
//  Width: rejected_cnt is KEY_W+1 bits so it can hold 2^KEY_W without overflow.
// CONFIGURATION
//  KEY_SWEEP_REJCNT_EN defined: rejected_cnt counts as described above.
//  KEY_SWEEP_REJCNT_EN undefined: counter logic omitted; rejected_cnt tied to 0.
//   Port list is identical in both builds.
// TESTING (bench instantiates the miter top with KEY_W=5, IN_W=5, OUT_W=2)
//  1. Reset, then start pulse -> done after sweep; found=1, key_found=5'h15 (10101),
//     first key to pass all 32 patterns.
//  2. KEY_SWEEP_REJCNT_EN defined, same run as 1 -> rejected_cnt=21 at done.
//     Undefined -> rejected_cnt=0 throughout.
//  3. Stub miter with z forced 0 -> 32 candidates each rejected after 1 cycle;
//     done at cycle 34 after start, found=0, key=5'h1F; rejected_cnt=32 if enabled.
//  4. Stub z=1 always -> found=1, key_found=0, done 34 cycles after start, pi=5'h1F.
//  5. Assert R=0 mid-sweep (key=3) -> all outputs zero same cycle, no done; new start
//     restarts from key=0.
//  6. Pulse start while busy, and again in the FINISH cycle -> ignored; one done pulse only.

Source files
------------

// File: rtl/key_sweep_ctrl.sv
// key_sweep_ctrl: brute-force locking-key sweep that drives a locked/original miter and consumes its Z/Q.
// Optional rejected-key counter is built only when KEY_SWEEP_REJCNT_EN is defined.
module key_sweep_ctrl #(
  parameter int unsigned KEY_W = 5,
  parameter int unsigned IN_W  = 5,
  parameter int unsigned OUT_W = 2
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  output logic [KEY_W-1:0] key,
  output logic [IN_W-1:0]  pi,
  input  logic             z,
  input  logic [OUT_W-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [KEY_W-1:0] key_found,
  output logic [OUT_W-1:0] bad_out,
  output logic [KEY_W:0]   rejected_cnt
);

  localparam int unsigned CNT_W = KEY_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IN_W-1:0]  pi_q, pi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [KEY_W-1:0] key_found_q, key_found_d;
  logic [OUT_W-1:0] bad_out_q, bad_out_d;
  logic             start_sweep_c;

  // start is honoured only while idle; a pulse in SWEEP or FINISH is dropped
  assign start_sweep_c = (state_q == ST_IDLE) && start;

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    pi_d        = pi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    found_d     = found_q;
    key_found_d = key_found_q;
    bad_out_d   = bad_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_sweep_c) begin
          state_d     = ST_SWEEP;
          key_d       = '0;
          pi_d        = '0;
          busy_d      = 1'b1;
          found_d     = 1'b0;
          key_found_d = '0;
          bad_out_d   = '0;
        end
      end

      ST_SWEEP: begin
        bad_out_d = bad_out_q | ~q;
        if (!z) begin
          // Candidate fails on this pattern: move to the next key, or stop at the last one
          pi_d = '0;
          if (&key_q) begin
            state_d = ST_FINISH;
          end else begin
            key_d = key_q + KEY_W'(1);
          end
        end else if (&pi_q) begin
          found_d     = 1'b1;
          key_found_d = key_q;
          state_d     = ST_FINISH;
        end else begin
          pi_d = pi_q + IN_W'(1);
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      pi_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      key_found_q <= '0;
      bad_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      pi_q        <= pi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      key_found_q <= key_found_d;
      bad_out_q   <= bad_out_d;
    end
  end

`ifdef KEY_SWEEP_REJCNT_EN
  logic [CNT_W-1:0] rej_cnt_q, rej_cnt_d;
  logic             reject_c;

  // One extra bit lets the counter reach 2^KEY_W when every key is rejected
  assign reject_c = (state_q == ST_SWEEP) && !z;

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (start_sweep_c) begin
      rej_cnt_d = '0;
    end else if (reject_c) begin
      rej_cnt_d = rej_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      rej_cnt_q <= '0;
    end else begin
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign rejected_cnt = rej_cnt_q;
`else
  assign rejected_cnt = '0;
`endif

  assign key       = key_q;
  assign pi        = pi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign key_found = key_found_q;
  assign bad_out   = bad_out_q;

endmodule

// File: tb/tb_key_sweep_ctrl.sv
// Bench for key_sweep_ctrl: table-driven miter stub with randomized rows and a
// reference model that scans the tables to predict each sweep's outcome.
module tb_key_sweep_ctrl;

  localparam int unsigned KEY_W = 5;
  localparam int unsigned IN_W  = 5;
  localparam int unsigned OUT_W = 2;
  localparam int NK = 1 << KEY_W;
  localparam int NP = 1 << IN_W;

  logic             C     = 1'b0;
  logic             R     = 1'b0;
  logic             start = 1'b0;
  logic [KEY_W-1:0] key;
  logic [IN_W-1:0]  pi;
  logic             z;
  logic [OUT_W-1:0] q;
  logic             busy;
  logic             done;
  logic             found;
  logic [KEY_W-1:0] key_found;
  logic [OUT_W-1:0] bad_out;
  logic [KEY_W:0]   rejected_cnt;

  // Miter stub: response tables indexed by the driven key and pattern
  bit               ztab [NK][NP];
  logic [OUT_W-1:0] qtab [NK][NP];

  assign z = ztab[key][pi];
  assign q = qtab[key][pi];

  int n_chk       = 0;
  int n_fail      = 0;
  int done_pulses = 0;

  // Reference-model results
  int               m_samples;
  int               m_rej;
  bit               m_found;
  logic [KEY_W-1:0] m_kf;
  logic [KEY_W-1:0] m_key;
  logic [IN_W-1:0]  m_pi;
  logic [OUT_W-1:0] m_bad;

  key_sweep_ctrl #(
    .KEY_W(KEY_W),
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) dut (
    .C           (C),
    .R           (R),
    .start       (start),
    .key         (key),
    .pi          (pi),
    .z           (z),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .key_found   (key_found),
    .bad_out     (bad_out),
    .rejected_cnt(rejected_cnt)
  );

  always #5 C = ~C;

  always @(negedge C) if (done === 1'b1) done_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Row k matches on patterns below fail_at, mismatches at fail_at, random afterwards
  task automatic set_row(input int k, input int fail_at);
    for (int p = 0; p < NP; p++) begin
      bit zz;
      if (p < fail_at)       zz = 1'b1;
      else if (p == fail_at) zz = 1'b0;
      else                   zz = 1'($urandom_range(0, 1));
      ztab[k][p] = zz;
      qtab[k][p] = zz ? '1 : OUT_W'($urandom_range(0, 2));
    end
  endtask

  // Walk the tables as the sweep should: keys ascending, patterns ascending, stop at first mismatch
  task automatic model();
    m_samples = 0;
    m_rej     = 0;
    m_found   = 1'b0;
    m_kf      = '0;
    m_bad     = '0;
    for (int k = 0; k < NK && !m_found; k++) begin
      int p;
      for (p = 0; p < NP; p++) begin
        m_samples++;
        m_bad |= ~qtab[k][p];
        if (!ztab[k][p]) break;
      end
      if (p == NP) begin
        m_found = 1'b1;
        m_kf    = KEY_W'(k);
      end else begin
        m_rej++;
      end
    end
    m_key = m_found ? m_kf : '1;
    m_pi  = m_found ? '1 : '0;
  endtask

  task automatic run_sweep(input string tag, input bit poke);
    int n;
    int exp_cyc;
    int pulses0;
    int exp_rej;
    model();
    exp_cyc = m_samples + 2;
`ifdef KEY_SWEEP_REJCNT_EN
    exp_rej = m_rej;
`else
    exp_rej = 0;
`endif
    pulses0 = done_pulses;
    @(posedge C); #1 start = 1'b1;
    @(posedge C); #1 start = 1'b0;
    n = 1;
    chk({tag, "_busy_start"}, 32'(busy), 1);
    chk({tag, "_key_start"}, 32'(key), 0);
    chk({tag, "_found_start"}, 32'(found), 0);
    while (done !== 1'b1 && n < exp_cyc + 20) begin
      if (poke && (n == 2 || n == exp_cyc - 1)) start = 1'b1;
      else                                     start = 1'b0;
      @(posedge C); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_found"}, 32'(found), 32'(m_found));
    chk({tag, "_key_found"}, 32'(key_found), 32'(m_kf));
    chk({tag, "_key"}, 32'(key), 32'(m_key));
    chk({tag, "_pi"}, 32'(pi), 32'(m_pi));
    chk({tag, "_bad_out"}, 32'(bad_out), 32'(m_bad));
    chk({tag, "_rejected"}, 32'(rejected_cnt), 32'(exp_rej));
    chk({tag, "_busy_end"}, 32'(busy), 0);
    @(posedge C); #1;
    chk({tag, "_done_width"}, 32'(done), 0);
    repeat (3) @(posedge C);
    #1;
    chk({tag, "_idle_after"}, 32'(busy), 0);
    chk({tag, "_done_pulses"}, 32'(done_pulses - pulses0), 1);
  endtask

  initial begin
    int pk;
    int n;
    int pulses0;

    // Reset values while R is held low
    #1;
    chk("rst_key", 32'(key), 0);
    chk("rst_pi", 32'(pi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_key_found", 32'(key_found), 0);
    chk("rst_bad_out", 32'(bad_out), 0);
    chk("rst_rejected", 32'(rejected_cnt), 0);
    repeat (3) @(negedge C);
    R = 1'b1;

    // Directed: 5'h15 is the first key to match on all patterns; start pokes while busy
    for (int k = 0; k < NK; k++) begin
      if (k < 21)       set_row(k, int'($urandom_range(0, NP - 1)));
      else if (k == 21) set_row(k, NP);
      else              set_row(k, int'($urandom_range(0, NP)));
    end
    run_sweep("first_match", 1'b1);
    chk("first_match_key_15", 32'(key_found), 32'h15);
`ifdef KEY_SWEEP_REJCNT_EN
    chk("first_match_rej_21", 32'(rejected_cnt), 21);
`else
    chk("first_match_rej_off", 32'(rejected_cnt), 0);
`endif

    // z stuck low: every key rejected after one pattern
    for (int k = 0; k < NK; k++) set_row(k, 0);
    run_sweep("z_low", 1'b0);
    chk("z_low_key_1f", 32'(key), 32'h1F);

    // z stuck high: key 0 accepted after all patterns
    for (int k = 0; k < NK; k++) set_row(k, NP);
    run_sweep("z_high", 1'b1);
    chk("z_high_pi_1f", 32'(pi), 32'h1F);

    // Reset mid-sweep at key 3
    for (int k = 0; k < NK; k++) set_row(k, 0);
    pulses0 = done_pulses;
    @(posedge C); #1 start = 1'b1;
    @(posedge C); #1 start = 1'b0;
    n = 0;
    while (key !== KEY_W'(3) && n < 20) begin
      @(posedge C); #1;
      n++;
    end
    chk("mid_rst_reached_key3", 32'(key), 3);
    #2 R = 1'b0;
    #1;
    chk("mid_rst_key", 32'(key), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_bad_out", 32'(bad_out), 0);
    chk("mid_rst_rejected", 32'(rejected_cnt), 0);
    chk("mid_rst_pi_found", 32'({pi, found, done, key_found}), 0);
    repeat (3) @(negedge C);
    chk("mid_rst_no_done", 32'(done_pulses - pulses0), 0);
    R = 1'b1;
    run_sweep("restart", 1'b0);

    // Randomized tables: matching key anywhere, or none at all
    for (int r = 0; r < 6; r++) begin
      pk = int'($urandom_range(0, NK));
      for (int k = 0; k < NK; k++) begin
        if (k < pk)       set_row(k, int'($urandom_range(0, NP - 1)));
        else if (k == pk) set_row(k, NP);
        else              set_row(k, int'($urandom_range(0, NP)));
      end
      run_sweep($sformatf("rand%0d", r), r[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
